// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one UART transmitter among
// several byte requesters. Grants one requester, hands its byte to the
// transmitter with a one-cycle valid pulse, follows the transmitter Busy
// through a full frame and returns a DONE (or ERR on missing Busy) pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic                          TX_BUSY,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_VALID,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            DONE,
    output logic                          ERR,
    output logic [$clog2(NUM_REQ)-1:0]    OWNER,
    output logic                          ACTIVE
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IW-1:0]           ptr_r;
    logic [IW-1:0]           ptr_nxt_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_nxt_s;
    logic [DATA_WIDTH-1:0]   tx_data_nxt_s;
    logic                    tx_valid_nxt_s;
    logic [NUM_REQ-1:0]      gnt_nxt_s;
    logic [NUM_REQ-1:0]      done_nxt_s;
    logic                    err_nxt_s;
    logic [IW-1:0]           owner_nxt_s;
    logic                    active_nxt_s;
    logic [IW-1:0]           win_s;
    logic                    found_s;
    logic [IW:0]             idx_s;
    logic [IW-1:0]           owner_inc_s;
    logic [NUM_REQ-1:0]      one_s;

    assign one_s = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Round-robin search: first set request bit starting at the pointer, wrapping.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, ptr_r} + (IW+1)'(i);
            if (idx_s >= (IW+1)'(NUM_REQ)) begin
                idx_s = idx_s - (IW+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && REQ[idx_s[IW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IW-1:0];
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // Pointer value that places the owner just served at the lowest priority.
    always_comb begin
        if (OWNER == IW'(NUM_REQ-1)) begin
            owner_inc_s = '0;
        end else begin
            owner_inc_s = OWNER + IW'(1);
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        cnt_nxt_s      = cnt_r;
        tx_data_nxt_s  = TX_DATA;
        tx_valid_nxt_s = 1'b0;
        gnt_nxt_s      = '0;
        done_nxt_s     = '0;
        err_nxt_s      = 1'b0;
        owner_nxt_s    = OWNER;
        active_nxt_s   = ACTIVE;
        case (state_r)
            IDLE: begin
                if (found_s && !TX_BUSY) begin
                    tx_data_nxt_s  = REQ_DATA[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
                    owner_nxt_s    = win_s;
                    gnt_nxt_s      = one_s << win_s;
                    tx_valid_nxt_s = 1'b1;
                    cnt_nxt_s      = '0;
                    active_nxt_s   = 1'b1;
                    state_nxt_s    = WAIT_BUSY;
                end else begin
                    active_nxt_s   = 1'b0;
                    state_nxt_s    = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt_s = WAIT_DONE;
                end else if (cnt_r == CW'(BUSY_TIMEOUT-1)) begin
                    // Transmitter never acknowledged: abort and move on.
                    err_nxt_s    = 1'b1;
                    ptr_nxt_s    = owner_inc_s;
                    active_nxt_s = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    cnt_nxt_s    = cnt_r + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    done_nxt_s   = one_s << OWNER;
                    ptr_nxt_s    = owner_inc_s;
                    active_nxt_s = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s  = WAIT_DONE;
                end
            end
            default: begin
                active_nxt_s = 1'b0;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            cnt_r    <= '0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            GNT      <= '0;
            DONE     <= '0;
            ERR      <= 1'b0;
            OWNER    <= '0;
            ACTIVE   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            TX_DATA  <= tx_data_nxt_s;
            TX_VALID <= tx_valid_nxt_s;
            GNT      <= gnt_nxt_s;
            DONE     <= done_nxt_s;
            ERR      <= err_nxt_s;
            OWNER    <= owner_nxt_s;
            ACTIVE   <= active_nxt_s;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among several byte requesters. It selects a requester, latches that requester's byte, and issues a single-cycle DATA_VALID pulse to the transmitter. It then tracks the transmitter's Busy through one full frame and returns a completion or error pulse to the owning requester. It sits between the per-source front-ends and the UART TX top. Its outputs connect directly to the transmitter's data and DATA_VALID inputs, and its TX_BUSY input comes from the transmitter's Busy output.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width
- BUSY_TIMEOUT, 15, max cycles in WAIT_BUSY without TX_BUSY before abort (>=2)
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  NUM_REQ  per-requester request level; held until matching GNT bit
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- TX_BUSY  in  1  Busy from UART TX
- TX_DATA  out  DATA_WIDTH  byte to UART TX
- TX_VALID  out  1  DATA_VALID pulse to UART TX
- GNT  out  NUM_REQ  one-hot, 1-cycle pulse: byte latched
- DONE  out  NUM_REQ  one-hot, 1-cycle pulse: frame finished
- ERR  out  1  1-cycle pulse: TX_BUSY never rose
- OWNER  out  clog2(NUM_REQ)  index of current/last owner
- ACTIVE  out  1  high in WAIT_BUSY and WAIT_DONE

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- Reset values: state IDLE, TX_DATA 0, TX_VALID 0, GNT 0, DONE 0, ERR 0, OWNER 0, ACTIVE 0, round-robin pointer 0, timeout counter 0.
- **IDLE:**
  - Arbitration happens when REQ != 0 and TX_BUSY == 0.
  - Winner is the first set REQ bit searching from the pointer upward, wrapping past NUM_REQ-1 to 0.
  - On the arbitration edge: TX_DATA <= REQ_DATA slice of the winner, OWNER <= winner, GNT <= one-hot(winner), TX_VALID <= 1, counter <= 0, state -> WAIT_BUSY.
  - If TX_BUSY == 1, no arbitration occurs; the block stays in IDLE.
- **WAIT_BUSY:**
  - TX_VALID and GNT are low from the second cycle onward.
  - TX_BUSY == 1 -> state WAIT_DONE.
  - Otherwise the counter increments. When counter == BUSY_TIMEOUT-1 and TX_BUSY == 0: ERR pulse, pointer <= OWNER+1 (mod NUM_REQ), state IDLE. No DONE is issued on this path.
- **WAIT_DONE:** TX_BUSY == 0 -> DONE pulse on bit OWNER, pointer <= OWNER+1 (mod NUM_REQ), state IDLE.
- REQ and REQ_DATA are ignored outside IDLE. A requester must drop REQ in the cycle after it sees GNT, otherwise it is treated as a new request.
- TX_DATA holds its value from the arbitration edge until the next arbitration; it changes only on arbitration.
- The pointer advances only past the owner just served, so a continuously requesting source cannot starve the others.
- Reset asserted mid-frame: all registers return to reset values immediately. The in-flight transmitter frame is not tracked, and no DONE or ERR is produced for it.

## Timing
- Edge 0 samples REQ in IDLE. GNT, TX_VALID, TX_DATA, OWNER and ACTIVE are valid after edge 0, for one cycle (ACTIVE stays high).
- With the standard UART TX, Busy rises one cycle after DATA_VALID is sampled.
- DONE fires in the cycle after the edge that sees TX_BUSY fall. ACTIVE drops in that same cycle.
- Earliest next arbitration is the edge after DONE, so there is at least one IDLE cycle between frames.
- DONE and ERR are never high in the same cycle. At most one GNT bit and at most one DONE bit are high at any time.

## Test plan
- **Reset check.** Assert RST with REQ = 4'b1111, then release. Required: all outputs are 0 while RST is high. The first GNT is 4'b0001 and TX_DATA equals byte 0, e.g. 8'hA5.
- **Round-robin fairness.** Hold REQ = 4'b1111 continuously; the bench model drops Busy after 11 cycles. Required: GNT order 0,1,2,3,0, with DONE matching each grant, one frame each.
- **Single requester wrap.** Pointer is at 2; only REQ[1] is asserted, with data 8'h3C. Required: GNT = 4'b0010, TX_DATA = 8'h3C, TX_VALID high for exactly 1 cycle.
- **Timeout.** TX_BUSY is held at 0 after a grant to requester 3. Required: ERR pulses exactly BUSY_TIMEOUT cycles after TX_VALID. No DONE is issued. The next grant searches from requester 0.
- **Busy blocking.** TX_BUSY = 1 in IDLE while REQ[0] = 1. Required: no GNT until the cycle after TX_BUSY falls.
- **Reset mid-frame.** Assert RST in WAIT_DONE. Required: ACTIVE = 0 immediately and no DONE is produced. After release, the first grant goes to requester 0.
